// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle ops with one registered result stage, plus iterative MULT/DIV into HI/LO.
// Mul/div take WIDTH+1 edges; ready=0 meanwhile and any start is dropped, never queued.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [2:0]       alu_ctrl,
  output logic             jr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] C_AND = 3'b000;
  localparam logic [2:0] C_OR  = 3'b001;
  localparam logic [2:0] C_XOR = 3'b010;
  localparam logic [2:0] C_ADD = 3'b011;
  localparam logic [2:0] C_SLT = 3'b100;
  localparam logic [2:0] C_SUB = 3'b111;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_q;
  logic             md_mul, md_signed, neg_a, neg_b, b_zero;

  logic [2:0]       dec_ctrl;
  logic             dec_jr, dec_mfhi, dec_mflo, dec_mul, dec_div, dec_signed;
  logic [WIDTH-1:0] alu_res, a_abs, b_abs;
  logic             accept;

  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo, rem;

  assign ready  = (state == S_IDLE);
  assign busy   = ~ready;
  assign accept = start && ready;

  always_comb begin
    dec_ctrl   = C_ADD;
    dec_jr     = 1'b0;
    dec_mfhi   = 1'b0;
    dec_mflo   = 1'b0;
    dec_mul    = 1'b0;
    dec_div    = 1'b0;
    dec_signed = 1'b0;
    case (ALUop)
      2'b00: dec_ctrl = C_ADD;
      2'b01: dec_ctrl = C_SUB;
      2'b11: dec_ctrl = C_OR;
      default: begin
        case (func)
          F_ADD:   dec_ctrl = C_ADD;
          F_SUB:   dec_ctrl = C_SUB;
          F_AND:   dec_ctrl = C_AND;
          F_OR:    dec_ctrl = C_OR;
          F_XOR:   dec_ctrl = C_XOR;
          F_SLT:   dec_ctrl = C_SLT;
          F_JR:    dec_jr   = 1'b1;
          F_MFHI:  dec_mfhi = 1'b1;
          F_MFLO:  dec_mflo = 1'b1;
          F_MULT:  begin dec_mul = 1'b1; dec_signed = 1'b1; end
          F_MULTU: dec_mul = 1'b1;
          F_DIV:   begin dec_div = 1'b1; dec_signed = 1'b1; end
          F_DIVU:  dec_div = 1'b1;
          default: dec_ctrl = C_ADD;
        endcase
      end
    endcase
  end

  always_comb begin
    case (dec_ctrl)
      C_AND:   alu_res = a & b;
      C_OR:    alu_res = a | b;
      C_XOR:   alu_res = a ^ b;
      C_SUB:   alu_res = a - b;
      C_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = a + b;
    endcase
    if (dec_jr)   alu_res = a;
    if (dec_mfhi) alu_res = hi;
    if (dec_mflo) alu_res = lo;
  end

  // The iterative core works on magnitudes; signs are reapplied in FIX.
  assign a_abs = (dec_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs = (dec_signed && b[WIDTH-1]) ? -b : b;

  // Mul: acc_hi:acc_lo is the partial product, multiplier bits retire from acc_lo[0].
  // Div: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
  assign div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd};

  assign prod   = {acc_hi, acc_lo};
  assign prod_s = (md_signed && (neg_a ^ neg_b)) ? -prod : prod;
  assign quo    = (md_signed && (neg_a ^ neg_b)) ? -acc_lo : acc_lo;
  assign rem    = (md_signed && neg_a) ? -acc_hi : acc_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      acc_hi       <= '0;
      acc_lo       <= '0;
      opnd         <= '0;
      a_q          <= '0;
      md_mul       <= 1'b0;
      md_signed    <= 1'b0;
      neg_a        <= 1'b0;
      neg_b        <= 1'b0;
      b_zero       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      alu_ctrl     <= 3'b000;
      jr           <= 1'b0;
      done         <= 1'b0;
      div_by_zero  <= 1'b0;
      hi           <= '0;
      lo           <= '0;
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      div_by_zero  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_ctrl <= dec_ctrl;
            if (dec_mul || dec_div) begin
              state     <= S_ITER;
              cnt       <= '0;
              jr        <= 1'b0;
              md_mul    <= dec_mul;
              md_signed <= dec_signed;
              neg_a     <= dec_signed && a[WIDTH-1];
              neg_b     <= dec_signed && b[WIDTH-1];
              b_zero    <= (b == '0);
              a_q       <= a;
              acc_hi    <= '0;
              acc_lo    <= dec_mul ? b_abs : a_abs;
              opnd      <= dec_mul ? a_abs : b_abs;
            end else begin
              result       <= alu_res;
              jr           <= dec_jr;
              result_valid <= 1'b1;
            end
          end
        end
        S_ITER: begin
          if (md_mul) begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end else if (!div_trial[WIDTH]) begin
            acc_hi <= div_trial[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= S_FIX;
        end
        S_FIX: begin
          state <= S_IDLE;
          done  <= 1'b1;
          if (md_mul) begin
            {hi, lo} <= prod_s;
          end else if (b_zero) begin
            lo          <= '1;
            hi          <= a_q;
            div_by_zero <= 1'b1;
          end else begin
            lo <= quo;
            hi <= rem;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit at WIDTH=32 and WIDTH=8 with hand-computed expectations.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, ready, result_valid, jr, busy, done, div_by_zero;
  logic [1:0]  ALUop;
  logic [5:0]  func;
  logic [31:0] a, b, result, hi, lo;
  logic [2:0]  alu_ctrl;

  logic       reset8, start8, ready8, result_valid8, jr8, busy8, done8, dbz8;
  logic [1:0] ALUop8;
  logic [5:0] func8;
  logic [7:0] a8, b8, result8, hi8, lo8;
  logic [2:0] alu_ctrl8;

  alu_exec_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUop(ALUop), .func(func), .a(a), .b(b),
    .ready(ready), .result(result), .result_valid(result_valid), .alu_ctrl(alu_ctrl), .jr(jr),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero));

  alu_exec_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .ALUop(ALUop8), .func(func8), .a(a8), .b(b8),
    .ready(ready8), .result(result8), .result_valid(result_valid8), .alu_ctrl(alu_ctrl8), .jr(jr8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8));

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] va;
    logic [31:0] vb;
    logic [2:0]  ctrl;
    logic [31:0] res;
    logic        jr_e;
    logic        chk_res;
  } vec_t;

  vec_t vecs [12] = '{
    '{2'b00, 6'b000000, 32'd5,        32'd3,        3'b011, 32'd8,        1'b0, 1'b1},
    '{2'b01, 6'b000000, 32'd5,        32'd3,        3'b111, 32'd2,        1'b0, 1'b1},
    '{2'b11, 6'b000000, 32'd5,        32'd3,        3'b001, 32'd7,        1'b0, 1'b1},
    '{2'b10, 6'b100000, 32'hFFFFFFFF, 32'd2,        3'b011, 32'd1,        1'b0, 1'b1},
    '{2'b10, 6'b100010, 32'd3,        32'd5,        3'b111, 32'hFFFFFFFE, 1'b0, 1'b1},
    '{2'b10, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 3'b000, 32'h0000F000, 1'b0, 1'b1},
    '{2'b10, 6'b100101, 32'h0000F0F0, 32'h00000F0F, 3'b001, 32'h0000FFFF, 1'b0, 1'b1},
    '{2'b10, 6'b100110, 32'h0000FF00, 32'h00000FF0, 3'b010, 32'h0000F0F0, 1'b0, 1'b1},
    '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        3'b100, 32'd1,        1'b0, 1'b1},
    '{2'b10, 6'b101010, 32'd1,        32'hFFFFFFFF, 3'b100, 32'd0,        1'b0, 1'b1},
    '{2'b10, 6'b001000, 32'h00001234, 32'h00000055, 3'b011, 32'h00001234, 1'b1, 1'b1},
    '{2'b10, 6'b111111, 32'd2,        32'd3,        3'b011, 32'd0,        1'b0, 1'b0}
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a mul/div on the 32-bit unit and count cycles observed with ready=0.
  task automatic md_run(input logic [5:0] f, input logic [31:0] va, input logic [31:0] vb,
                        output int cyc);
    ALUop = 2'b10; func = f; a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    chk("md_no_result_valid", result_valid, 1'b0);
    chk("md_busy", busy, 1'b1);
    cyc = 0;
    while (!ready && cyc < 100) begin
      chk("md_no_early_done", done, 1'b0);
      cyc++;
      tick();
    end
  endtask

  initial begin
    int cyc;
    int pulses;
    reset = 1'b1; start = 1'b0; ALUop = 2'b00; func = 6'd0; a = '0; b = '0;
    reset8 = 1'b1; start8 = 1'b0; ALUop8 = 2'b00; func8 = 6'd0; a8 = '0; b8 = '0;
    tick(); tick();
    reset = 1'b0; reset8 = 1'b0;

    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_alu_ctrl", alu_ctrl, 3'b000);
    chk("rst_jr", jr, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dbz", div_by_zero, 1'b0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // sub 5-7, one-cycle result_valid pulse
    ALUop = 2'b10; func = 6'b100010; a = 32'd5; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    chk("sub_result", result, 32'hFFFFFFFE);
    chk("sub_ctrl", alu_ctrl, 3'b111);
    chk("sub_valid", result_valid, 1'b1);
    tick();
    chk("sub_valid_drop", result_valid, 1'b0);
    chk("sub_result_hold", result, 32'hFFFFFFFE);

    // decode sweep, accepted back-to-back
    for (int i = 0; i < 12; i++) begin
      ALUop = vecs[i].op; func = vecs[i].fn; a = vecs[i].va; b = vecs[i].vb; start = 1'b1;
      tick();
      chk($sformatf("dec%0d_ctrl", i), alu_ctrl, vecs[i].ctrl);
      chk($sformatf("dec%0d_jr", i), jr, vecs[i].jr_e);
      chk($sformatf("dec%0d_valid", i), result_valid, 1'b1);
      if (vecs[i].chk_res) chk($sformatf("dec%0d_result", i), result, vecs[i].res);
    end
    start = 1'b0;
    tick();
    chk("dec_valid_drop", result_valid, 1'b0);

    // MULT / MULTU
    md_run(6'b011000, 32'hFFFFFFFD, 32'd7, cyc);
    chk("mult_busy_cycles", cyc, 33);
    chk("mult_done", done, 1'b1);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    tick();
    chk("mult_done_drop", done, 1'b0);

    md_run(6'b011001, 32'hFFFFFFFD, 32'd7, cyc);
    chk("multu_busy_cycles", cyc, 33);
    chk("multu_done", done, 1'b1);
    chk("multu_hi", hi, 32'h00000006);
    chk("multu_lo", lo, 32'hFFFFFFEB);

    // DIV / DIVU corner cases
    md_run(6'b011010, 32'hFFFFFFF9, 32'd2, cyc);
    chk("div_busy_cycles", cyc, 33);
    chk("div_done", done, 1'b1);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_dbz", div_by_zero, 1'b0);

    md_run(6'b011011, 32'd7, 32'd0, cyc);
    chk("divu0_done", done, 1'b1);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'd7);
    chk("divu0_dbz", div_by_zero, 1'b1);
    tick();
    chk("divu0_dbz_drop", div_by_zero, 1'b0);

    md_run(6'b011010, 32'h80000000, 32'hFFFFFFFF, cyc);
    chk("divmin_done", done, 1'b1);
    chk("divmin_lo", lo, 32'h80000000);
    chk("divmin_hi", hi, 32'd0);

    // mflo held during a busy DIVU: ignored until ready, then returns the new LO
    ALUop = 2'b10; func = 6'b011011; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    func = 6'b010010;
    cyc = 0; pulses = 0;
    while (!ready && cyc < 100) begin
      if (result_valid) pulses++;
      chk("hold_lo_unchanged", lo, 32'h80000000);
      cyc++;
      tick();
    end
    chk("hold_busy_cycles", cyc, 33);
    chk("hold_no_result", pulses, 0);
    chk("hold_done", done, 1'b1);
    chk("hold_valid_at_done", result_valid, 1'b0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    tick();
    start = 1'b0;
    chk("mflo_valid", result_valid, 1'b1);
    chk("mflo_result", result, 32'd14);
    ALUop = 2'b10; func = 6'b010000; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mfhi_result", result, 32'd2);
    tick();
    chk("mfhi_valid_drop", result_valid, 1'b0);

    // reset 10 cycles into a MULT
    ALUop = 2'b10; func = 6'b011000; a = 32'd5; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_done", done, 1'b0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    chk("midrst_lo_stays", lo, 32'd0);

    // WIDTH=8: 9-edge latency, then reset mid-op
    ALUop8 = 2'b10; func8 = 6'b011000; a8 = 8'hFD; b8 = 8'd7; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cyc = 0;
    while (!ready8 && cyc < 100) begin
      cyc++;
      tick();
    end
    chk("w8_busy_cycles", cyc, 9);
    chk("w8_done", done8, 1'b1);
    chk("w8_hi", hi8, 8'hFF);
    chk("w8_lo", lo8, 8'hEB);
    tick();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset8 = 1'b1;
    tick();
    reset8 = 1'b0;
    chk("w8_midrst_ready", ready8, 1'b1);
    chk("w8_midrst_hi", hi8, 8'h00);
    chk("w8_midrst_lo", lo8, 8'h00);
    chk("w8_midrst_done", done8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
